bit_in_capture: RTL and testbench



---
 rtl/bit_in_capture.sv | 108 ++++++++++
 tb/tb_bit_in_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bit_in_capture.sv
// Debounced input port with sticky rising-edge capture and maskable IRQ.
// Avalon-MM slave: DATA, MASK, CAPTURE (W1C) registers.
module bit_in_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             csi_clk,
  input  logic             csi_reset,
  input  logic [1:0]       avs_s1_address,
  input  logic             avs_s1_read,
  output logic [7:0]       avs_s1_readdata,
  input  logic             avs_s1_write,
  input  logic [7:0]       avs_s1_writedata,
  input  logic [WIDTH-1:0] coe_in,
  output logic             ins_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic [7:0]       rd_mux;
  logic             wr_mask;
  logic             wr_cap;

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= coe_in;
      sync2 <= sync1;
    end
  end

  // Any return to the stable level clears the count, so short glitches vanish.
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge csi_clk or posedge csi_reset) begin
      if (csi_reset) begin
        cnt       <= '0;
        stable[i] <= 1'b0;
      end else if (sync2[i] == stable[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt       <= '0;
        stable[i] <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) stable_d <= '0;
    else           stable_d <= stable;
  end

  assign rise    = stable & ~stable_d;
  assign wdata   = avs_s1_writedata[WIDTH-1:0];
  assign wr_mask = avs_s1_write && (avs_s1_address == 2'd1);
  assign wr_cap  = avs_s1_write && (avs_s1_address == 2'd2);
  assign clr     = wr_cap ? wdata : '0;

  // OR-ing rise last keeps a new edge even when it lands on a clear.
  assign cap_next  = (cap & ~clr) | rise;
  assign mask_next = wr_mask ? wdata : mask;

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      cap     <= '0;
      mask    <= '0;
      ins_irq <= 1'b0;
    end else begin
      cap     <= cap_next;
      mask    <= mask_next;
      ins_irq <= |(cap_next & mask_next);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs_s1_address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = mask;
      2'd2:    rd_mux[WIDTH-1:0] = cap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset)        avs_s1_readdata <= '0;
    else if (avs_s1_read) avs_s1_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_bit_in_capture.sv
// Directed bench for bit_in_capture with DEBOUNCE_CYCLES=4, WIDTH=4.
// Pin-to-DATA latency is 2+4 clocks; readdata lags one more.
module tb_bit_in_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] addr;
  logic       rd;
  logic [7:0] rdata;
  logic       wr;
  logic [7:0] wdata;
  logic [3:0] pins;
  logic       irq;

  int vecs = 0;
  int errs = 0;

  bit_in_capture #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .csi_clk(clk),
    .csi_reset(rst),
    .avs_s1_address(addr),
    .avs_s1_read(rd),
    .avs_s1_readdata(rdata),
    .avs_s1_write(wr),
    .avs_s1_writedata(wdata),
    .coe_in(pins),
    .ins_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rreg(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    rd   = 1'b1;
    tick();
    rd   = 1'b0;
    v    = rdata;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0;
    wdata = '0; pins = '0;
    tick(3);
    rst = 1'b0;
    tick();

    chk("rst_irq", {7'd0, irq}, 8'h00);
    rreg(2'd0, v); chk("rst_data", v, 8'h00);
    rreg(2'd1, v); chk("rst_mask", v, 8'h00);
    rreg(2'd2, v); chk("rst_cap", v, 8'h00);

    wreg(2'd1, 8'h01);
    chk("mask_only_irq", {7'd0, irq}, 8'h00);

    // Clean press with DATA read every clock.
    pins = 4'b0001;
    addr = 2'd0;
    rd   = 1'b1;
    tick(6);
    chk("press_rd_t6", rdata, 8'h00);
    chk("press_irq_t6", {7'd0, irq}, 8'h00);
    tick();
    chk("press_rd_t7", rdata, 8'h01);
    chk("press_irq_t7", {7'd0, irq}, 8'h01);
    rd = 1'b0;
    rreg(2'd2, v); chk("press_cap", v, 8'h01);

    wreg(2'd2, 8'h01);
    chk("w1c_irq", {7'd0, irq}, 8'h00);
    rreg(2'd2, v); chk("w1c_cap", v, 8'h00);

    // Three-clock glitch on bit 2.
    pins = 4'b0101;
    tick(3);
    pins = 4'b0001;
    tick(10);
    rreg(2'd0, v); chk("glitch_data", v, 8'h01);
    rreg(2'd2, v); chk("glitch_cap", v, 8'h00);
    chk("glitch_irq", {7'd0, irq}, 8'h00);

    // Release: DATA falls, falling edge not captured.
    pins = 4'b0000;
    addr = 2'd0;
    rd   = 1'b1;
    tick(6);
    chk("rel_rd_t6", rdata, 8'h01);
    tick();
    chk("rel_rd_t7", rdata, 8'h00);
    rd = 1'b0;
    rreg(2'd2, v); chk("rel_cap", v, 8'h00);

    // Press again; clear lands on the clock rise[0] is high.
    pins = 4'b0001;
    tick(6);
    wreg(2'd2, 8'h01);
    chk("race_irq", {7'd0, irq}, 8'h01);
    rreg(2'd2, v); chk("race_cap", v, 8'h01);

    wreg(2'd2, 8'h01);
    wreg(2'd1, 8'h00);
    pins = 4'b1001;
    tick(10);
    rreg(2'd2, v); chk("mask_cap", v, 8'h08);
    chk("masked_irq", {7'd0, irq}, 8'h00);
    wreg(2'd1, 8'h08);
    chk("unmask_irq", {7'd0, irq}, 8'h01);
    wreg(2'd1, 8'h00);
    chk("remask_irq", {7'd0, irq}, 8'h00);

    rreg(2'd3, v); chk("addr3_rd", v, 8'h00);
    wreg(2'd0, 8'hFF);
    rreg(2'd0, v); chk("data_ro", v, 8'h09);
    wreg(2'd3, 8'hFF);
    rreg(2'd1, v); chk("addr3_wr_mask", v, 8'h00);
    rreg(2'd2, v); chk("addr3_wr_cap", v, 8'h08);

    // Read and write in one cycle returns the old value.
    addr  = 2'd1;
    wdata = 8'h05;
    rd    = 1'b1;
    wr    = 1'b1;
    tick();
    rd = 1'b0;
    wr = 1'b0;
    chk("rw_old", rdata, 8'h00);
    rreg(2'd1, v); chk("rw_new", v, 8'h05);
    wreg(2'd1, 8'hF8);
    rreg(2'd1, v); chk("mask_upper", v, 8'h08);
    chk("pre_rst_irq", {7'd0, irq}, 8'h01);

    // Asynchronous reset mid-cycle with flags pending.
    #2;
    rst = 1'b1;
    #1;
    chk("async_irq", {7'd0, irq}, 8'h00);
    chk("async_rdata", rdata, 8'h00);
    #13;
    rst = 1'b0;
    tick();
    rreg(2'd2, v); chk("post_rst_cap", v, 8'h00);
    tick(8);
    rreg(2'd0, v); chk("post_rst_data", v, 8'h09);
    rreg(2'd2, v); chk("post_rst_recap", v, 8'h09);
    rreg(2'd1, v); chk("post_rst_mask", v, 8'h00);
    chk("post_rst_irq", {7'd0, irq}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
